vend_controller: RTL and testbench

- Top-level sequencing FSM of the vending machine.
- Collects a two-key selection (letter + digit) and presents it to the external price-lookup block.
- Accumulates coin credit, pulses dispense once paid, then hands out change or a refund.
- Sits between keypad/coin-acceptor front ends and the dispenser/change-return hardware.

---
 rtl/vend_pkg.sv | 40 ++++
 rtl/vend_credit_acc.sv | 47 ++++
 rtl/vend_controller.sv | 186 ++++++++++++++++++
 tb/tb_vend_controller.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types and constants for the vending controller
package vend_pkg;

    localparam int CENTS_W = 13;
    localparam int CODE_W  = 16;

    localparam logic [3:0] KEY_LETTER_MIN = 4'hA;

    localparam logic [1:0] COIN_5C   = 2'b00;
    localparam logic [1:0] COIN_10C  = 2'b01;
    localparam logic [1:0] COIN_25C  = 2'b10;
    localparam logic [1:0] COIN_100C = 2'b11;

    localparam logic [CENTS_W-1:0] VAL_5C   = 13'd5;
    localparam logic [CENTS_W-1:0] VAL_10C  = 13'd10;
    localparam logic [CENTS_W-1:0] VAL_25C  = 13'd25;
    localparam logic [CENTS_W-1:0] VAL_100C = 13'd100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIGIT,
        ST_CHECK,
        ST_PAY,
        ST_DISPENSE,
        ST_CHANGE,
        ST_ERROR
    } vend_state_e;

    function automatic logic [CENTS_W-1:0] coin_value(input logic [1:0] coin_type);
        logic [CENTS_W-1:0] v;
        case (coin_type)
            COIN_5C:   v = VAL_5C;
            COIN_10C:  v = VAL_10C;
            COIN_25C:  v = VAL_25C;
            default:   v = VAL_100C;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vend_credit_acc.sv
// rtl/vend_credit_acc.sv - coin decode, credit ceiling check, credit register and coin reject pulse
module vend_credit_acc
    import vend_pkg::*;
#(
    parameter int MAX_CREDIT = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               coin_valid,
    input  logic [1:0]         coin_type,
    input  logic               add_en,
    input  logic               sub_en,
    input  logic [CENTS_W-1:0] sub_amt,
    input  logic               clr_en,
    output logic [CENTS_W-1:0] credit,
    output logic [CENTS_W:0]   coin_sum,
    output logic               coin_accept,
    output logic               coin_reject
);

    // One extra bit so a sum beyond the 13-bit range still compares correctly
    assign coin_sum    = {1'b0, credit} + {1'b0, coin_value(coin_type)};
    assign coin_accept = coin_valid && add_en && (coin_sum <= (CENTS_W+1)'(MAX_CREDIT));

    // Credit register: clear beats subtract beats coin add
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit <= '0;
        end else if (clr_en) begin
            credit <= '0;
        end else if (sub_en) begin
            credit <= credit - sub_amt;
        end else if (coin_accept) begin
            credit <= coin_sum[CENTS_W-1:0];
        end
    end

    // Any coin not taken into credit is returned with a one-cycle pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coin_reject <= 1'b0;
        end else begin
            coin_reject <= coin_valid && !coin_accept;
        end
    end

endmodule

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - vending sequencing FSM; optional inactivity timeout under VEND_TIMEOUT_EN
module vend_controller
    import vend_pkg::*;
#(
    parameter int MAX_CREDIT     = 1000,
    parameter int ERR_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_valid,
    input  logic [3:0]         key,
    input  logic               cancel,
    input  logic               coin_valid,
    input  logic [1:0]         coin_type,
    output logic [CODE_W-1:0]  code,
    input  logic               code_v,
    input  logic [CENTS_W-1:0] price,
    output logic               coin_reject,
    output logic               err,
    output logic               dispense,
    output logic [CENTS_W-1:0] credit,
    output logic               change_valid,
    output logic [CENTS_W-1:0] change_amt,
    input  logic               change_ack,
    output logic               busy
);

    localparam int ERR_W = (ERR_CYCLES < 2) ? 1 : $clog2(ERR_CYCLES + 1);

    vend_state_e        state, state_nx;
    logic [7:0]         code_q, code_nx;
    logic [CENTS_W-1:0] price_q, price_nx;
    logic [ERR_W-1:0]   err_cnt;
    logic               add_en, sub_en, clr_en;
    logic               coin_accept;
    logic [CENTS_W:0]   coin_sum;
    logic               timeout;
    logic               is_letter;

    assign is_letter = (key >= KEY_LETTER_MIN);

    vend_credit_acc #(
        .MAX_CREDIT (MAX_CREDIT)
    ) u_credit (
        .clk         (clk),
        .rst_n       (rst_n),
        .coin_valid  (coin_valid),
        .coin_type   (coin_type),
        .add_en      (add_en),
        .sub_en      (sub_en),
        .sub_amt     (price_q),
        .clr_en      (clr_en),
        .credit      (credit),
        .coin_sum    (coin_sum),
        .coin_accept (coin_accept),
        .coin_reject (coin_reject)
    );

`ifdef VEND_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] idle_cnt;
    logic            waiting;

    assign waiting = (state == ST_DIGIT) || (state == ST_PAY);
    assign timeout = waiting && !key_valid && !coin_valid
                     && (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Inactivity counter, restarted by any user activity or state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (!waiting || key_valid || coin_valid || (state_nx != state)) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    // Keeps the timeout parameter referenced when the timeout is built out
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout = 1'b0;
`endif

    // State, selection code and latched price
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            code_q  <= '0;
            price_q <= '0;
        end else begin
            state   <= state_nx;
            code_q  <= code_nx;
            price_q <= price_nx;
        end
    end

    // Dwell counter for the ERROR state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (state != ST_ERROR) begin
            err_cnt <= '0;
        end else begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    // Next-state, code/price updates and credit commands
    always_comb begin
        state_nx = state;
        code_nx  = code_q;
        price_nx = price_q;
        add_en   = (state == ST_PAY);
        sub_en   = 1'b0;
        clr_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (key_valid && is_letter) begin
                    code_nx  = {key, 4'h0};
                    state_nx = ST_DIGIT;
                end
            end
            ST_DIGIT: begin
                if (cancel || timeout) begin
                    code_nx  = '0;
                    state_nx = ST_IDLE;
                end else if (key_valid && is_letter) begin
                    code_nx[7:4] = key;
                end else if (key_valid) begin
                    code_nx[3:0] = key;
                    state_nx     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (code_v) begin
                    price_nx = price;
                    state_nx = ST_PAY;
                end else begin
                    state_nx = ST_ERROR;
                end
            end
            ST_PAY: begin
                // A coin arriving with cancel is still credited, so it is refunded
                if (cancel || timeout) begin
                    state_nx = ST_CHANGE;
                end else if (coin_accept && (coin_sum >= {1'b0, price_q})) begin
                    state_nx = ST_DISPENSE;
                end
            end
            ST_DISPENSE: begin
                sub_en   = 1'b1;
                state_nx = ST_CHANGE;
            end
            ST_CHANGE: begin
                if (credit == '0) begin
                    code_nx  = '0;
                    state_nx = ST_IDLE;
                end else if (change_ack) begin
                    clr_en   = 1'b1;
                    code_nx  = '0;
                    state_nx = ST_IDLE;
                end
            end
            ST_ERROR: begin
                if (err_cnt == ERR_W'(ERR_CYCLES - 1)) begin
                    code_nx  = '0;
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                code_nx  = '0;
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign code         = {8'h00, code_q};
    assign busy         = (state != ST_IDLE);
    assign err          = (state == ST_ERROR);
    assign dispense     = (state == ST_DISPENSE);
    assign change_valid = (state == ST_CHANGE) && (credit != '0);
    assign change_amt   = change_valid ? credit : '0;

endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - scoreboard testbench for vend_controller
`timescale 1ns/1ps
module tb_vend_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic [3:0]  key;
    logic        cancel;
    logic        coin_valid;
    logic [1:0]  coin_type;
    logic [15:0] code;
    logic        code_v;
    logic [12:0] price;
    logic        coin_reject;
    logic        err;
    logic        dispense;
    logic [12:0] credit;
    logic        change_valid;
    logic [12:0] change_amt;
    logic        change_ack;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int code;
        int cyc;
    } disp_t;

    disp_t exp_disp[$];
    int    exp_change[$];
    int    exp_rej[$];
    int    exp_err[$];

    vend_controller #(
        .MAX_CREDIT     (1000),
        .ERR_CYCLES     (8),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_valid    (key_valid),
        .key          (key),
        .cancel       (cancel),
        .coin_valid   (coin_valid),
        .coin_type    (coin_type),
        .code         (code),
        .code_v       (code_v),
        .price        (price),
        .coin_reject  (coin_reject),
        .err          (err),
        .dispense     (dispense),
        .credit       (credit),
        .change_valid (change_valid),
        .change_amt   (change_amt),
        .change_ack   (change_ack),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Price lookup table
    always_comb begin
        code_v = 1'b1;
        case (code)
            16'h00A1: price = 13'd100;
            16'h00B1: price = 13'd125;
            16'h00C2: price = 13'd75;
            16'h00E5: price = 13'd1050;
            default: begin
                price  = 13'd0;
                code_v = 1'b0;
            end
        endcase
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an event
    logic cv_prev = 1'b0;
    int   err_run = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            cv_prev <= 1'b0;
            err_run <= 0;
        end else begin
            if (dispense) begin
                if (exp_disp.size() == 0) begin
                    check("unexpected_dispense", 1, 0);
                end else begin
                    disp_t e;
                    e = exp_disp.pop_front();
                    check("dispense_code", int'(code), e.code);
                    check("dispense_cycle", cyc, e.cyc);
                end
            end
            if (change_valid && !cv_prev) begin
                if (exp_change.size() == 0) check("unexpected_change", int'(change_amt), 0);
                else check("change_amt", int'(change_amt), exp_change.pop_front());
            end
            if (coin_reject) begin
                if (exp_rej.size() == 0) check("unexpected_reject", 1, 0);
                else check("reject_credit", int'(credit), exp_rej.pop_front());
            end
            if (err) begin
                err_run <= err_run + 1;
            end else if (err_run > 0) begin
                if (exp_err.size() == 0) check("unexpected_err", err_run, 0);
                else check("err_cycles", err_run, exp_err.pop_front());
                err_run <= 0;
            end
            cv_prev <= change_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key       = k;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic coin(input logic [1:0] t);
        coin_valid = 1'b1;
        coin_type  = t;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic coin_cancel(input logic [1:0] t);
        coin_valid = 1'b1;
        coin_type  = t;
        cancel     = 1'b1;
        tick();
        coin_valid = 1'b0;
        cancel     = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    task automatic wait_change_ack(input int max_cyc);
        int n = 0;
        while (!change_valid && n < max_cyc) begin
            tick();
            n++;
        end
        if (!change_valid) check("change_valid_timeout", 0, 1);
        change_ack = 1'b1;
        tick();
        change_ack = 1'b0;
        check("ack_idle_busy", int'(busy), 0);
        check("ack_credit", int'(credit), 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        key_valid  = 1'b0;
        key        = 4'h0;
        cancel     = 1'b0;
        coin_valid = 1'b0;
        coin_type  = 2'b00;
        change_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_code", int'(code), 0);
        check("rst_credit", int'(credit), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_flags", int'({coin_reject, err, dispense, change_valid}), 0);
        check("rst_change_amt", int'(change_amt), 0);
        rst_n = 1'b1;
        tick();

        // Exact payment
        press(4'h5);
        check("idle_digit_ignored", int'(busy), 0);
        press(4'hA);
        check("digit_busy", int'(busy), 1);
        check("letter_code", int'(code), 16'h00A0);
        press(4'h1);
        check("full_code", int'(code), 16'h00A1);
        tick();
        coin(2'b10); coin(2'b10); coin(2'b10);
        check("credit_75", int'(credit), 75);
        exp_disp.push_back('{code: 16'h00A1, cyc: cyc + 1});
        coin(2'b10);
        repeat (3) tick();
        check("exact_idle", int'(busy), 0);
        check("exact_credit", int'(credit), 0);

        // Overpaid, letter replaced in DIGIT
        press(4'hA);
        press(4'hB);
        press(4'h1);
        tick();
        coin(2'b11);
        exp_disp.push_back('{code: 16'h00B1, cyc: cyc + 1});
        exp_change.push_back(75);
        coin(2'b11);
        tick();
        for (int i = 0; i < 10; i++) begin
            check("change_hold", int'({change_valid, change_amt}), int'({1'b1, 13'd75}));
            tick();
        end
        wait_change_ack(5);
        check("over_code_clear", int'(code), 0);

        // Invalid code
        press(4'hD);
        press(4'h9);
        exp_err.push_back(8);
        tick();
        press(4'hA);
        exp_rej.push_back(0);
        coin(2'b10);
        repeat (10) tick();
        check("err_idle", int'(busy), 0);
        check("err_code_clear", int'(code), 0);

        // Cancel refunds
        press(4'hC); press(4'h2); tick();
        coin(2'b10); coin(2'b01);
        exp_change.push_back(35);
        do_cancel();
        wait_change_ack(5);

        press(4'hC); press(4'h2); tick();
        coin(2'b10); coin(2'b01);
        exp_change.push_back(60);
        coin_cancel(2'b10);
        wait_change_ack(5);

        press(4'hC); press(4'h2); tick();
        coin(2'b10); coin(2'b10);
        exp_change.push_back(75);
        coin_cancel(2'b10);
        wait_change_ack(5);

        // Credit ceiling
        press(4'hE); press(4'h5); tick();
        for (int i = 0; i < 10; i++) coin(2'b11);
        check("ceiling_credit", int'(credit), 1000);
        exp_rej.push_back(1000);
        coin(2'b11);
        exp_rej.push_back(1000);
        coin(2'b00);
        tick();
        check("ceiling_hold", int'(credit), 1000);

        // Asynchronous reset mid-PAY
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_credit", int'(credit), 0);
        check("arst_code", int'(code), 0);
        check("arst_flags", int'({coin_reject, err, dispense, change_valid}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        exp_rej.push_back(0);
        coin(2'b01);
        tick();
        check("post_rst_credit", int'(credit), 0);

`ifdef VEND_TIMEOUT_EN
        press(4'hA); press(4'h1); tick();
        exp_change.push_back(10);
        coin(2'b01);
        repeat (15) tick();
        check("timeout_not_early", int'(change_valid), 0);
        wait_change_ack(20);
`endif

        repeat (4) tick();
        check("left_disp", exp_disp.size(), 0);
        check("left_change", exp_change.size(), 0);
        check("left_rej", exp_rej.size(), 0);
        check("left_err", exp_err.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
